data_gen_multi: RTL

//  Parametrised test-pattern source for the 6-digit 7-seg/595 display path.
//  A prescaled tick advances a sign/magnitude value in one of four counting modes.

---
 rtl/data_gen_multi_pkg.sv | 25 ++
 rtl/data_gen_multi_tick_gen.sv | 42 ++++
 rtl/data_gen_multi.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/data_gen_multi_pkg.sv
// Shared types and constants for the 7-seg test-pattern generator.
// Mode encodings match the 2-bit mode input of data_gen_multi.
package data_gen_multi_pkg;

    localparam int DATA_W = 20;
    localparam logic [DATA_W-1:0] DISP_MAX = 20'd999_999;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_SIGNED = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic logic [DATA_W-1:0] clamp_mag(input logic [DATA_W-1:0] val,
                                                    input logic [DATA_W-1:0] lim);
        return (val > lim) ? lim : val;
    endfunction

endpackage

// File: rtl/data_gen_multi_tick_gen.sv
// Prescaler: counts 0..CNT_WAIT_MAX while run is high and emits a registered
// one-clock tick; clr restarts the period and drops any pending tick.
module data_gen_multi_tick_gen #(
    parameter logic [22:0] CNT_WAIT_MAX = 23'd4_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam logic [22:0] CNT_PRE = CNT_WAIT_MAX - 23'd1;

    logic [22:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d  = (cnt_q == CNT_WAIT_MAX) ? '0 : cnt_q + 23'd1;
            tick_d = (cnt_q == CNT_PRE);
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/data_gen_multi.sv
// Test-pattern source for the 6-digit display path: a prescaled tick advances a
// sign/magnitude value in up, down, bounce or signed-up mode, with clr > load > tick.
module data_gen_multi
    import data_gen_multi_pkg::*;
#(
    parameter logic [22:0] CNT_WAIT_MAX = 23'd4_999_999,
    parameter logic [19:0] NUM_MAX      = 20'd999_999,
    parameter logic [19:0] STEP         = 20'd1,
    parameter logic [5:0]  POINT_DEF    = 6'b000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [1:0]  mode,
    input  logic        run,
    input  logic        clr,
    input  logic        load,
    input  logic [19:0] load_val,
    input  logic        load_sign,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en,
    output logic        wrap
);

    localparam logic [DATA_W-1:0] MAG_MAX = clamp_mag(NUM_MAX, DISP_MAX);
    localparam logic [DATA_W-1:0] UP_LIM  = MAG_MAX - STEP;

    mode_e             mode_s;
    logic              tick;
    logic [DATA_W-1:0] load_mag;

    logic [DATA_W-1:0] data_q, data_d;
    logic              sign_q, sign_d;
    dir_e              dir_q, dir_d;
    logic              wrap_q, wrap_d;
    logic              seg_en_q;

    assign mode_s   = mode_e'(mode);
    assign load_mag = clamp_mag(load_val, MAG_MAX);

    data_gen_multi_tick_gen #(
        .CNT_WAIT_MAX(CNT_WAIT_MAX)
    ) u_tick_gen (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .run      (run),
        .clr      (clr),
        .tick     (tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_q   <= '0;
            sign_q   <= 1'b0;
            dir_q    <= DIR_UP;
            wrap_q   <= 1'b0;
            seg_en_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            sign_q   <= sign_d;
            dir_q    <= dir_d;
            wrap_q   <= wrap_d;
            seg_en_q <= 1'b1;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        data_d = data_q;
        sign_d = sign_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        if (clr) begin
            data_d = '0;
            sign_d = 1'b0;
            dir_d  = DIR_UP;
        end else if (load) begin
            data_d = load_mag;
            sign_d = load_sign && (mode_s == MODE_SIGNED) && (load_mag != '0);
        end else if (tick) begin
            case (mode_s)
                MODE_UP: begin
                    if (data_q > UP_LIM) begin
                        data_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        data_d = data_q + STEP;
                    end
                end
                MODE_DOWN: begin
                    if (data_q < STEP) begin
                        data_d = MAG_MAX;
                        wrap_d = 1'b1;
                    end else begin
                        data_d = data_q - STEP;
                    end
                end
                MODE_BOUNCE: begin
                    if (dir_q == DIR_UP) begin
                        if (data_q > UP_LIM) begin
                            data_d = MAG_MAX;
                            dir_d  = DIR_DOWN;
                            wrap_d = 1'b1;
                        end else begin
                            data_d = data_q + STEP;
                        end
                    end else if (data_q < STEP) begin
                        data_d = '0;
                        dir_d  = DIR_UP;
                        wrap_d = 1'b1;
                    end else begin
                        data_d = data_q - STEP;
                    end
                end
                MODE_SIGNED: begin
                    // Negative values move toward zero by magnitude and cross it exactly.
                    if (!sign_q && (data_q > UP_LIM)) begin
                        data_d = MAG_MAX;
                        sign_d = 1'b1;
                        wrap_d = 1'b1;
                    end else if (!sign_q) begin
                        data_d = data_q + STEP;
                    end else if (data_q > STEP) begin
                        data_d = data_q - STEP;
                    end else begin
                        data_d = STEP - data_q;
                        sign_d = 1'b0;
                    end
                end
            endcase
        end
        if (mode_s != MODE_SIGNED) sign_d = 1'b0;
        if (mode_s != MODE_BOUNCE) dir_d = DIR_UP;
    end

    // Sign is masked combinationally so leaving signed mode hides it at once.
    always_comb begin
        data   = data_q;
        point  = POINT_DEF;
        sign   = sign_q && (mode_s == MODE_SIGNED);
        seg_en = seg_en_q;
        wrap   = wrap_q;
    end

endmodule
